// File: rtl/datarx_pkg.sv
// datarx_pkg: receiver FSM state type and the bit-order helper shared by the datarx files.
package datarx_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  localparam int MAX_WIDTH = 64;

  // Reverses the low w bits of v; bits at and above w come back as zero.
  function automatic logic [MAX_WIDTH-1:0] bit_rev(input logic [MAX_WIDTH-1:0] v, input int w);
    logic [MAX_WIDTH-1:0] r;
    r = {<<{v}};
    return r >> (MAX_WIDTH - w);
  endfunction

endpackage

// File: rtl/datarx_shift.sv
// datarx_shift: serial shift register and slot bit counter; exposes the current window,
// the raw payload bits and a slot-boundary strobe.
module datarx_shift #(
  parameter int WIDTH = 8,
  parameter int SRW   = 8
) (
  input  logic             clk_400MHz,
  input  logic             reset_n,
  input  logic             en,
  input  logic             data_in,
  input  logic             cnt_clr,
  input  logic             long_slot,
  output logic [WIDTH-1:0] window,
  output logic [WIDTH-1:0] word_raw,
  output logic             word_par,
  output logic             boundary
);

  localparam int CW = $clog2(SRW);
  localparam logic [CW-1:0] LAST_SHORT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_LONG  = CW'(SRW - 1);

  // The oldest bit of the extended window is never needed again, so only SRW-1 bits are stored.
  logic [SRW-2:0] sr_reg;
  logic [SRW-1:0] ext;
  logic [CW-1:0]  bit_cnt_reg;

  assign ext      = {sr_reg, data_in};
  assign window   = ext[WIDTH-1:0];
  assign word_raw = ext[SRW-1 -: WIDTH];
  assign word_par = ^ext;
  assign boundary = en && (bit_cnt_reg == (long_slot ? LAST_LONG : LAST_SHORT));

  always_ff @(posedge clk_400MHz or negedge reset_n) begin
    if (!reset_n) begin
      sr_reg      <= '0;
      bit_cnt_reg <= '0;
    end else if (en) begin
      sr_reg      <= ext[SRW-2:0];
      bit_cnt_reg <= (cnt_clr || boundary) ? '0 : bit_cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/datarx_frame.sv
// datarx_frame: frame-aligned serial-to-parallel receiver with sync hunt, lock confirmation and loss detection.
// Optional build macro DATARX_PARITY_EN adds a trailing even-parity bit per payload word and parity_err.
module datarx_frame
  import datarx_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
  parameter int               FRAME_WORDS = 4,
  parameter int               LOCK_COUNT  = 2,
  parameter int               MISS_LIMIT  = 2,
  parameter bit               MSB_FIRST   = 1'b1
) (
  input  logic             clk_400MHz,
  input  logic             reset_n,
  input  logic             data_in,
  input  logic             en,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             sync_locked,
  output logic             sync_err
`ifdef DATARX_PARITY_EN
  ,
  output logic             parity_err
`endif
);

`ifdef DATARX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int SRW = WIDTH + PAR;
  localparam int WCW = $clog2(FRAME_WORDS + 1);
  localparam int HCW = $clog2(LOCK_COUNT + 1);
  localparam int MCW = $clog2(MISS_LIMIT + 1);

  rx_state_t            state_reg;
  logic [WCW-1:0]       word_cnt_reg, word_cnt_wrap;
  logic [HCW-1:0]       hits_reg;
  logic [MCW-1:0]       misses_reg;
  logic [WIDTH-1:0]     data_out_reg;
  logic                 data_valid_reg, sync_locked_reg, sync_err_reg;
  logic [WIDTH-1:0]     window, word_raw, cmp_word, out_word;
  logic [MAX_WIDTH-1:0] win_rev, raw_rev;
  logic                 word_par, boundary, is_sync, sync_hit, cnt_clr;
  logic                 unused_bits;

  datarx_shift #(.WIDTH(WIDTH), .SRW(SRW)) u_shift (
    .clk_400MHz (clk_400MHz),
    .reset_n    (reset_n),
    .en         (en),
    .data_in    (data_in),
    .cnt_clr    (cnt_clr),
    .long_slot  ((PAR != 0) && !is_sync),
    .window     (window),
    .word_raw   (word_raw),
    .word_par   (word_par),
    .boundary   (boundary)
  );

  // SYNC_WORD is given in output bit order, so LSB-first links compare the reversed window.
  assign win_rev  = bit_rev(MAX_WIDTH'(window), WIDTH);
  assign raw_rev  = bit_rev(MAX_WIDTH'(word_raw), WIDTH);
  assign cmp_word = MSB_FIRST ? window : win_rev[WIDTH-1:0];
  assign out_word = MSB_FIRST ? word_raw : raw_rev[WIDTH-1:0];
  assign sync_hit = (cmp_word == SYNC_WORD);
  assign is_sync  = (word_cnt_reg == '0);
  assign cnt_clr  = (state_reg == HUNT) && sync_hit;
  assign word_cnt_wrap = (word_cnt_reg == WCW'(FRAME_WORDS)) ? '0 : word_cnt_reg + WCW'(1);

`ifdef DATARX_PARITY_EN
  assign unused_bits = ^{win_rev[MAX_WIDTH-1:WIDTH], raw_rev[MAX_WIDTH-1:WIDTH]};
`else
  assign unused_bits = ^{win_rev[MAX_WIDTH-1:WIDTH], raw_rev[MAX_WIDTH-1:WIDTH], word_par};
`endif

  always_ff @(posedge clk_400MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= HUNT;
      word_cnt_reg    <= '0;
      hits_reg        <= '0;
      misses_reg      <= '0;
      data_out_reg    <= '0;
      data_valid_reg  <= 1'b0;
      sync_locked_reg <= 1'b0;
      sync_err_reg    <= 1'b0;
`ifdef DATARX_PARITY_EN
      parity_err      <= 1'b0;
`endif
    end else begin
      data_valid_reg <= 1'b0;
      sync_err_reg   <= 1'b0;
      if (en) begin
        unique case (state_reg)
          HUNT: begin
            if (sync_hit) begin
              // The matched window was the sync word itself; the next slot is payload word 1.
              word_cnt_reg <= WCW'(1);
              hits_reg     <= HCW'(1);
              misses_reg   <= '0;
              if (LOCK_COUNT == 1) begin
                state_reg       <= LOCKED;
                sync_locked_reg <= 1'b1;
              end else begin
                state_reg <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (boundary) begin
              word_cnt_reg <= word_cnt_wrap;
              if (is_sync) begin
                if (!sync_hit) begin
                  state_reg <= HUNT;
                end else begin
                  hits_reg <= hits_reg + HCW'(1);
                  if (hits_reg + HCW'(1) == HCW'(LOCK_COUNT)) begin
                    state_reg       <= LOCKED;
                    sync_locked_reg <= 1'b1;
                  end
                end
              end
            end
          end
          LOCKED: begin
            if (boundary) begin
              word_cnt_reg <= word_cnt_wrap;
              if (is_sync) begin
                if (sync_hit) begin
                  misses_reg <= '0;
                end else begin
                  sync_err_reg <= 1'b1;
                  misses_reg   <= misses_reg + MCW'(1);
                  if (misses_reg + MCW'(1) == MCW'(MISS_LIMIT)) begin
                    state_reg       <= HUNT;
                    sync_locked_reg <= 1'b0;
                  end
                end
              end else begin
                data_out_reg   <= out_word;
                data_valid_reg <= 1'b1;
`ifdef DATARX_PARITY_EN
                parity_err     <= word_par;
`endif
              end
            end
          end
          default: state_reg <= HUNT;
        endcase
      end
    end
  end

  assign data_out    = data_out_reg;
  assign data_valid  = data_valid_reg;
  assign sync_locked = sync_locked_reg;
  assign sync_err    = sync_err_reg;

endmodule

// File: tb/tb_datarx_frame.sv
// tb_datarx_frame: directed bench for datarx_frame (MSB-first/LOCK_COUNT=2 and LSB-first/LOCK_COUNT=1 instances).
module tb_datarx_frame;

  logic       clk_400MHz = 1'b0;
  logic       reset_n, data_in, en;
  logic [7:0] data_out, data_out2;
  logic       data_valid, sync_locked, sync_err;
  logic       data_valid2, sync_locked2, sync_err2;
`ifdef DATARX_PARITY_EN
  logic       parity_err, parity_err2;
`endif

  int         tests_run = 0;
  int         tests_failed = 0;
  int         err_cnt = 0;
  bit         gap_mode = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always #1 clk_400MHz = ~clk_400MHz;

  datarx_frame u_dut (
    .clk_400MHz  (clk_400MHz),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .en          (en),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .sync_locked (sync_locked),
    .sync_err    (sync_err)
`ifdef DATARX_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  datarx_frame #(.MSB_FIRST(1'b0), .LOCK_COUNT(1)) u_dut_lsb (
    .clk_400MHz  (clk_400MHz),
    .reset_n     (reset_n),
    .data_in     (data_in),
    .en          (en),
    .data_out    (data_out2),
    .data_valid  (data_valid2),
    .sync_locked (sync_locked2),
    .sync_err    (sync_err2)
`ifdef DATARX_PARITY_EN
    ,
    .parity_err  (parity_err2)
`endif
  );

  // Transaction monitor for the main instance: one line per received word or sync error.
  always @(negedge clk_400MHz) begin
    if (data_valid) begin
      got_q.push_back(data_out);
      $display("[TB] word %02h", data_out);
    end
    if (sync_err) begin
      err_cnt++;
      $display("[TB] sync_err pulse");
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input logic b, input logic e);
    data_in = b;
    en      = e;
    @(negedge clk_400MHz);
  endtask

  task automatic settle();
    tick(1'b0, 1'b0);
  endtask

  task automatic send_bit(input logic b);
    if (gap_mode) begin
      while ($urandom_range(0, 99) < 30) tick(1'($urandom_range(0, 1)), 1'b0);
    end
    tick(b, 1'b1);
  endtask

  task automatic send_word(input logic [7:0] w, input bit lsb);
    logic [7:0] t;
    t = w;
    for (int i = 0; i < 8; i++) begin
      send_bit(lsb ? t[0] : t[7]);
      t = lsb ? (t >> 1) : (t << 1);
    end
  endtask

  task automatic send_payload(input logic [7:0] w, input bit lsb);
    send_word(w, lsb);
`ifdef DATARX_PARITY_EN
    send_bit(^w);
`endif
  endtask

  task automatic check_stream(input string tag);
    logic [7:0] g;
    check_eq($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    foreach (exp_q[i]) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      check_eq($sformatf("%s_w%0d", tag, i), g, exp_q[i]);
    end
    got_q.delete();
  endtask

  task automatic run_lock(input string tag);
    logic [7:0] t;
    err_cnt = 0;
    got_q.delete();
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_word(8'hA5, 1'b0);
    send_payload(8'h11, 1'b0);
    send_payload(8'h22, 1'b0);
    send_payload(8'h33, 1'b0);
    send_payload(8'h44, 1'b0);
    t = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      send_bit(t[7]);
      t = t << 1;
      if (i == 6) check_eq($sformatf("%s_lock_early", tag), sync_locked, 1'b0);
    end
    check_eq($sformatf("%s_lock_rise", tag), sync_locked, 1'b1);
    send_payload(8'h55, 1'b0);
    send_payload(8'h66, 1'b0);
    send_payload(8'h77, 1'b0);
    send_payload(8'h88, 1'b0);
    send_word(8'hA5, 1'b0);
    send_payload(8'h99, 1'b0);
    settle();
    exp_q = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    check_stream(tag);
    check_eq($sformatf("%s_no_err", tag), err_cnt, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    data_in = 1'b0;
    en      = 1'b0;
    repeat (3) @(negedge clk_400MHz);
    check_eq("rst_data_out", data_out, 8'h00);
    check_eq("rst_valid", data_valid, 1'b0);
    check_eq("rst_locked", sync_locked, 1'b0);
    check_eq("rst_err", sync_err, 1'b0);
`ifdef DATARX_PARITY_EN
    check_eq("rst_parity", parity_err, 1'b0);
`endif
    reset_n = 1'b1;
    settle();

    run_lock("lock");

    // Sync loss: one miss keeps lock, the second consecutive miss drops it.
    err_cnt = 0;
    send_payload(8'hAA, 1'b0);
    send_payload(8'hBB, 1'b0);
    send_payload(8'hCC, 1'b0);
    send_word(8'hA4, 1'b0);
    check_eq("miss1_err", sync_err, 1'b1);
    check_eq("miss1_locked", sync_locked, 1'b1);
    send_payload(8'hD1, 1'b0);
    check_eq("miss1_next_valid", data_valid, 1'b1);
    check_eq("miss1_next_data", data_out, 8'hD1);
    check_eq("miss1_err_count", err_cnt, 1);
    send_payload(8'hD2, 1'b0);
    send_payload(8'hD3, 1'b0);
    send_payload(8'hD4, 1'b0);
    send_word(8'hA4, 1'b0);
    check_eq("miss2_err", sync_err, 1'b1);
    check_eq("miss2_locked", sync_locked, 1'b0);
    settle();
    check_eq("miss2_err_width", sync_err, 1'b0);
    check_eq("miss2_data_held", data_out, 8'hD4);
    check_eq("miss2_err_count", err_cnt, 2);
    exp_q = '{8'hAA, 8'hBB, 8'hCC, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
    check_stream("loss");

    // Reset asserted mid-word clears outputs and lock history.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    reset_n = 1'b0;
    settle();
    check_eq("mid_rst_data", data_out, 8'h00);
    check_eq("mid_rst_locked", sync_locked, 1'b0);
    check_eq("mid_rst_valid", data_valid, 1'b0);
    reset_n = 1'b1;
    settle();

    gap_mode = 1'b1;
    run_lock("gap");
    check_eq("gap_data_held", data_out, 8'h99);
    gap_mode = 1'b0;

    // LSB-first instance locks on a single sync word.
    reset_n = 1'b0;
    settle();
    reset_n = 1'b1;
    settle();
    send_word(8'hA5, 1'b1);
    check_eq("lsb_locked", sync_locked2, 1'b1);
    check_eq("lsb_no_valid", data_valid2, 1'b0);
    send_payload(8'h01, 1'b1);
    check_eq("lsb_valid", data_valid2, 1'b1);
    check_eq("lsb_data01", data_out2, 8'h01);
    send_payload(8'hC2, 1'b1);
    check_eq("lsb_dataC2", data_out2, 8'hC2);

`ifdef DATARX_PARITY_EN
    reset_n = 1'b0;
    settle();
    reset_n = 1'b1;
    settle();
    send_word(8'hA5, 1'b0);
    send_payload(8'h11, 1'b0);
    send_payload(8'h22, 1'b0);
    send_payload(8'h33, 1'b0);
    send_payload(8'h44, 1'b0);
    send_word(8'hA5, 1'b0);
    check_eq("par_locked", sync_locked, 1'b1);
    send_word(8'h03, 1'b0);
    send_bit(1'b1);
    check_eq("par_bad_valid", data_valid, 1'b1);
    check_eq("par_bad_data", data_out, 8'h03);
    check_eq("par_bad_flag", parity_err, 1'b1);
    send_word(8'h03, 1'b0);
    send_bit(1'b0);
    check_eq("par_good_valid", data_valid, 1'b1);
    check_eq("par_good_flag", parity_err, 1'b0);
`endif

    settle();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/datarx_frame.md
# datarx_frame

Parametrised, frame-aligned serial-to-parallel receiver: the next generation of the single-lane 8-bit deserializer. It shifts in one bit per enabled clock and finds word boundaries by hunting for a programmable sync word, instead of free-running from reset. It confirms lock over several frames, then emits payload words with a valid strobe. It sits directly behind the serial line input and feeds the word-wide datapath.

## Interface
- WIDTH, 8: bits per word (≥4).
- SYNC_WORD, 8'hA5: WIDTH-bit alignment pattern heading every frame.
- FRAME_WORDS, 4: payload words per frame (≥1).
- LOCK_COUNT, 2: consecutive correctly placed sync words needed to declare lock (≥1).
- MISS_LIMIT, 2: consecutive missed sync words that drop lock (≥1).
- MSB_FIRST, 1: 1 = first received bit of a word lands in bit WIDTH-1; 0 = lands in bit 0.

- clk_400MHz  in  1  bit clock; sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- data_in  in  1  serial bit, sampled on rising clk_400MHz when en=1.
- en  in  1  bit-valid qualifier; en=0 freezes all state.
- data_out  out  WIDTH  last payload word, registered, held between strobes.
- data_valid  out  1  one-cycle pulse: data_out updated.
- sync_locked  out  1  high in LOCKED.
- sync_err  out  1  one-cycle pulse: expected sync word absent while LOCKED.

## Operation
- Shift register sr (WIDTH bits). Each enabled edge computes window = {sr[WIDTH-2:0], data_in} and stores it in sr. Compares use window, never stale sr.
- Bit counter 0..WIDTH-1 and word counter 0..FRAME_WORDS track position once aligned. Word index 0 = sync slot.
- States:
  - HUNT: compare window to SYNC_WORD on every enabled bit. On a match, clear the counters, set hits=1, and enter CONFIRM, or LOCKED if LOCK_COUNT=1.
  - CONFIRM: at each word boundary in the sync slot, a match increments hits, and hits==LOCK_COUNT enters LOCKED. A mismatch returns to HUNT. Payload slots are skipped with no data_valid.
  - LOCKED: at each payload boundary, register the word to data_out and pulse data_valid. At a sync-slot boundary, a match clears misses. A mismatch pulses sync_err and increments misses, the frame continues at the same alignment, and misses==MISS_LIMIT enters HUNT.
- MSB_FIRST=0: output word and SYNC_WORD comparison use the bit-reversed window. SYNC_WORD is always specified in output bit order.
- Leaving LOCKED clears sync_locked on the same edge. data_out keeps its last value.
- en=0: no shift, no counting, no pulses. Pulses last exactly one clock even if en drops.
- Reset values: data_out=0, data_valid=0, sync_locked=0, sync_err=0, sr=0, counters=0, state HUNT. Reset asserted mid-frame discards the partial word and all lock history.

## Timing
- Latency: data_valid, data_out, sync_err and sync_locked are registered on the edge that samples the word's last bit, so they are visible the following cycle.
- Sync and payload boundaries are back-to-back. There is no idle bit between words or frames.
- Maximum data_valid rate is one pulse per WIDTH enabled clocks.
- Simultaneous events: a missed sync that also reaches MISS_LIMIT gives a sync_err pulse and drops lock on the same edge.
- Counters wrap: bit WIDTH-1 → 0, word FRAME_WORDS → 0.

## Configuration
- DATARX_PARITY_EN defined:
  - Every payload word carries one trailing even-parity bit, making a payload slot WIDTH+1 bits. The sync word carries no parity.
  - Adds output parity_err (1 bit), valid with data_valid, reset 0. It is high when the parity over data bits plus the parity bit is odd.
  - The word is still output when parity fails.
- DATARX_PARITY_EN undefined: payload slots are WIDTH bits, and the parity_err port and logic are absent.

## Structure
- datarx_pkg holds the state enum (HUNT, CONFIRM, LOCKED) and a bit-reverse function.
- Sub-module datarx_shift contains the shift register, bit counter and window/boundary outputs. The top level holds the FSM, word/hit/miss counters and output registers.

## Test plan
- Reset: hold reset_n=0 mid-stream → all outputs 0. Release, then send 3 junk bits + A5 → no data_valid before lock.
- Lock, defaults (LOCK_COUNT=2, FRAME_WORDS=4) → stream A5,11,22,33,44,A5,55,66,77,88,A5,99 (MSB first):
  - sync_locked rises the cycle after the second A5's last bit.
  - data_valid fires with 55,66,77,88, then 99.
  - 11..44 are not output.
- Sync loss: locked, then sync slot A4 → one sync_err pulse, lock held, next payload still output. A second consecutive bad sync → sync_err and sync_locked=0 on the same cycle.
- MSB_FIRST=0, SYNC_WORD=8'hA5: send bits of A5 LSB-first, then a payload word 1,0,0,0,0,0,0,0 → data_out=8'h01.
- en gaps: repeat the lock scenario with en low on random 30% of cycles → identical data_out sequence and pulse count.
- DATARX_PARITY_EN: send payload 8'h03 with parity bit 1 → parity_err=1 with data_valid and data_out=8'h03. Send the same word with parity bit 0 → parity_err=0.
